// File: rtl/fx_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : fx_mac_stream
// Purpose  : Streaming fixed-point multiply-accumulate. Accepts (A,B) term
//            pairs under valid/ready, accumulates full-precision products
//            and emits one rounded, saturated DWIDTH result per vector.
// Revision : 1.0  initial release
// ============================================================================
module fx_mac_stream #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int GUARD  = 8,
    parameter int ROUND  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] in_a,
    input  logic signed [DWIDTH-1:0] in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [DWIDTH-1:0] out_data,
    output logic                     out_ovf
);

    localparam int c_pw   = 2 * DWIDTH;
    localparam int c_accw = c_pw + GUARD;

    // Rounding bias: half an output LSB when rounding, nothing when truncating.
    localparam logic [c_accw-1:0] c_half =
        (ROUND != 0) ? ({{(c_accw-1){1'b0}}, 1'b1} << (FRAC - 1)) : '0;

    logic                     w_en;
    logic signed [c_pw-1:0]   w_prod;
    logic signed [c_accw-1:0] w_p_ext;
    logic signed [c_accw-1:0] w_acc_base;
    logic signed [c_accw-1:0] w_rnd;
    logic signed [c_accw-1:0] w_shr;
    logic                     w_in_range;

    logic signed [c_pw-1:0]   r_p;
    logic                     r_p_valid;
    logic                     r_p_last;
    logic signed [c_accw-1:0] r_acc;
    logic                     r_first;
    logic                     r_a_done;
    logic                     r_out_valid;
    logic        [DWIDTH-1:0] r_out_data;
    logic                     r_out_ovf;

    // Whole pipeline moves together; it only stalls when a result is stuck.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    assign w_prod     = in_a * in_b;
    assign w_p_ext    = {{GUARD{r_p[c_pw-1]}}, r_p};
    assign w_acc_base = r_first ? '0 : r_acc;
    assign w_rnd      = r_acc + c_half;
    assign w_shr      = w_rnd >>> FRAC;

    // Result fits when every bit from the output sign bit upward agrees.
    assign w_in_range = (&w_shr[c_accw-1:DWIDTH-1]) || !(|w_shr[c_accw-1:DWIDTH-1]);

    // Stage 1: register the full-width product of the accepted term.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p       <= '0;
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
        end else if (w_en) begin
            r_p       <= w_prod;
            r_p_valid <= in_valid;
            r_p_last  <= in_last;
        end
    end

    // Stage 2: accumulate; the first term of a vector overwrites the old sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_first  <= 1'b1;
            r_a_done <= 1'b0;
        end else if (w_en) begin
            if (r_p_valid) begin
                r_acc   <= w_acc_base + w_p_ext;
                r_first <= r_p_last;
            end
            r_a_done <= r_p_valid && r_p_last;
        end
    end

    // Stage 3: round, saturate and hold the result until it is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_en) begin
            if (r_a_done) begin
                r_out_valid <= 1'b1;
                if (w_in_range) begin
                    r_out_data <= w_shr[DWIDTH-1:0];
                    r_out_ovf  <= 1'b0;
                end else if (!w_shr[c_accw-1]) begin
                    r_out_data <= {1'b0, {(DWIDTH-1){1'b1}}};
                    r_out_ovf  <= 1'b1;
                end else begin
                    r_out_data <= {1'b1, {(DWIDTH-1){1'b0}}};
                    r_out_ovf  <= 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fx_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fx_mac_stream
// Purpose  : Scoreboard bench for fx_mac_stream; a rounding and a truncating
//            instance share all inputs, each has its own expected queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_fx_mac_stream;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_ready = 1'b1;
    logic        in_ready, in_ready0;
    logic        out_valid, out_valid0;
    logic [31:0] out_data, out_data0;
    logic        out_ovf, out_ovf0;

    int n_vec = 0;
    int n_err = 0;
    logic signed [71:0] m_acc = '0;
    exp_t q1[$];
    exp_t q0[$];

    fx_mac_stream #(.DWIDTH(32), .FRAC(24), .GUARD(8), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    fx_mac_stream #(.DWIDTH(32), .FRAC(24), .GUARD(8), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_ovf(out_ovf0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: Q8.24 result of a wide sum, rounded or truncated, then clamped.
    function automatic exp_t model(input logic signed [71:0] acc, input bit rnd);
        logic signed [71:0] r;
        exp_t e;
        r = rnd ? acc + 72'sd8388608 : acc;
        r = r >>> 24;
        if (r > 72'sd2147483647) begin
            e.data = 32'h7FFFFFFF;
            e.ovf  = 1'b1;
        end else if (r < -72'sd2147483648) begin
            e.data = 32'h80000000;
            e.ovf  = 1'b1;
        end else begin
            e.data = r[31:0];
            e.ovf  = 1'b0;
        end
        return e;
    endfunction

    // Present one term and hold it until accepted; update the model on accept.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        logic signed [31:0] sa, sb;
        longint p;
        bit got;
        bit rdy;
        int k;
        got = 0;
        k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        while (!got && k < 200) begin
            #4;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) got = 1;
            else @(negedge clk);
            k++;
        end
        if (!got) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        sa = a;
        sb = b;
        p = longint'(sa) * longint'(sb);
        m_acc = m_acc + 72'(p);
        if (last) begin
            q1.push_back(model(m_acc, 1'b1));
            q0.push_back(model(m_acc, 1'b0));
            m_acc = '0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q1.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain_q", 64'(q1.size()), 64'd0);
    endtask

    // Scoreboard: compare every result that is handed over at the next edge.
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (!rst && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                chk("stale_result", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                chk("data_rnd", 64'(out_data), 64'(e.data));
                chk("ovf_rnd", 64'(out_ovf), 64'(e.ovf));
                e = q0.pop_front();
                chk("valid_trunc", 64'(out_valid0), 64'd1);
                chk("data_trunc", 64'(out_data0), 64'(e.data));
                chk("ovf_trunc", 64'(out_ovf0), 64'(e.ovf));
            end
        end
    end

    initial begin
        logic [31:0] held;
        int k;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single term 1.5*2.0 with a latency check.
        send(32'h01800000, 32'h02000000, 1'b1);
        idle();
        chk("lat_edge1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_edge2", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_edge3", 64'(out_valid), 64'd1);
        chk("lat_data", 64'(out_data), 64'h03000000);

        // Three-term vector followed back-to-back by a single-term vector.
        send(32'h01000000, 32'h00800000, 1'b0);
        send(32'h02000000, 32'h00800000, 1'b0);
        send(32'hFF800000, 32'h04000000, 1'b1);
        send(32'h01000000, 32'h01000000, 1'b1);
        // Saturation both ways.
        send(32'h64000000, 32'h64000000, 1'b1);
        send(32'h9C000000, 32'h64000000, 1'b1);
        // Rounding boundary at exactly half an LSB, positive and negative.
        send(32'h00000001, 32'h00800000, 1'b1);
        send(32'hFFFFFFFF, 32'h00800000, 1'b1);
        idle();
        drain();

        // Backpressure: results stall while further vectors queue up.
        fork
            begin
                for (int v = 0; v < 4; v++) begin
                    send(32'h01000000 + 32'(v) * 32'h00400000, 32'h00C00000, 1'b0);
                    send(32'hFF000000, 32'h00000100 * 32'(v + 1), 1'b1);
                end
                idle();
            end
            begin
                @(negedge clk);
                out_ready = 1'b0;
                k = 0;
                while (!out_valid && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_valid_seen", 64'(out_valid), 64'd1);
                held = out_data;
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                    chk("bp_hold", 64'(out_data), 64'(held));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random vectors of 1..4 terms with arbitrary operands.
        for (int v = 0; v < 6; v++) begin
            int n;
            n = $urandom_range(4, 1);
            for (int t = 0; t < n; t++)
                send($urandom, (v < 3) ? ($urandom & 32'h01FFFFFF) : $urandom, t == n - 1);
        end
        idle();
        drain();

        // Reset mid-vector discards the partial sum.
        send(32'h01000000, 32'h01000000, 1'b0);
        send(32'h01000000, 32'h01000000, 1'b0);
        idle();
        rst = 1'b1;
        m_acc = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        send(32'h03000000, 32'h01000000, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        chk("mid_rst_data", 64'(out_data), 64'h03000000);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fx_mac_stream.md
Name: fx_mac_stream

Overview:
- Parametrised fixed-point multiply-accumulate engine for neuron dot products: streams (A,B) term pairs, accumulates full-precision products, and emits one rounded, saturated DWIDTH result per vector.
- Successor to the combinational multiply/add primitives. Adds pipelining, a valid/ready handshake, a configurable rounding mode and saturation with an overflow flag.
- Sits between the weight/activation fetch logic and the sigmoid unit.

Parameters:
- DWIDTH, 32: data width of operands and result, signed two's complement.
- FRAC, 24: fractional bits of operands and result (Q(DWIDTH-FRAC).FRAC). Must satisfy 1 <= FRAC < DWIDTH.
- GUARD, 8: extra accumulator MSBs. Accumulator width ACCW = 2*DWIDTH+GUARD. Sums of up to 2^GUARD terms cannot wrap.
- ROUND, 1: 0 = truncate toward -inf (drop low FRAC bits, legacy behaviour); 1 = round half up (add 2^(FRAC-1) before shift).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  term pair present
- in_ready  out  1  engine can accept a term this cycle
- in_a  in  DWIDTH  signed operand A (activation)
- in_b  in  DWIDTH  signed operand B (weight)
- in_last  in  1  this term is the final term of the current vector
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  DWIDTH  signed rounded/saturated dot product
- out_ovf  out  1  out_data was saturated (qualified by out_valid)

Behaviour:
- Reset: when rst=1 at a rising edge, all pipeline valids clear, the accumulator clears, and the first-term flag sets. Outputs: out_valid=0, out_data=0, out_ovf=0, in_ready=1 in the following cycle. rst has priority over every other input. A reset mid-vector discards the partial sum; the next accepted term starts a new vector.
- Enable: en = !out_valid || out_ready. in_ready = en, combinational. The whole pipeline advances only when en=1; when en=0 every register holds.
- Accept: a term is taken at an edge where in_valid && in_ready. in_valid=0 cycles are bubbles and do not disturb the accumulator.
- Stage 1 (edge T): p <= in_a*in_b at full 2*DWIDTH signed width; p_valid <= accept; p_last <= in_last.
- Stage 2 (edge T+1, if p_valid): acc <= (first ? 0 : acc) + sign-extend(p). first <= p_last, so first is set after a last term and cleared otherwise. a_done <= p_valid && p_last.
- Stage 3 (edge T+2, if a_done):
  - r = (ROUND ? acc + 2^(FRAC-1) : acc) >>> FRAC, arithmetic shift, ACCW-bit.
  - If r > 2^(DWIDTH-1)-1: out_data = 0x7FF..F, out_ovf=1.
  - If r < -2^(DWIDTH-1): out_data = 0x800..0, out_ovf=1.
  - Otherwise out_data = r[DWIDTH-1:0], out_ovf=0.
  - out_valid <= 1.
- Output register: if a_done=0 and out_ready=1, out_valid <= 0. out_data and out_ovf hold while out_valid && !out_ready.
- Latency: the last term accepted at edge T gives out_valid=1 after edge T+2 (3 edges incl. T), assuming no stall. Throughput is 1 term/cycle with back-to-back vectors and no gap required. A single-term vector (in_last on the first term) is legal.
- Simultaneous events: a result leaving (out_ready=1) and a new result arriving (a_done) on the same edge gives a new out_data with out_valid staying 1.
- Boundary: more than 2^GUARD terms with extreme operands may wrap the accumulator. This is undetected and is the caller's responsibility. out_ovf reports output saturation only.

Test Plan:
- Single term, Q8.24, ROUND=1: A=0x01800000 (1.5), B=0x02000000 (2.0), last=1 -> out_data=0x03000000, out_ovf=0, out_valid exactly 3 edges after accept.
- Three-term vector: A={1.0,2.0,-0.5}, B={0.5,0.5,4.0} back-to-back, last on third -> out_data=0xFF800000 (-0.5). Immediately follow with the single-term vector 1.0*1.0 -> 0x01000000 on the next cycle.
- Saturation: 100.0*100.0 -> 0x7FFFFFFF, out_ovf=1. -100.0*100.0 -> 0x80000000, out_ovf=1.
- Rounding: A=0x00000001, B=0x00800000 (raw product 2^23) -> ROUND=1 gives 0x00000001, ROUND=0 gives 0x00000000. A=-1 LSB, same B -> ROUND=0 gives 0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles with terms pending -> in_ready=0, out_data stable. On release, every result appears in order with none lost or duplicated.
- Reset mid-vector: accept 2 terms of 1.0*1.0, assert rst 1 cycle, then send 3.0*1.0 with last -> out_data=0x03000000 and no stale result emitted.
